count_arbiter: RTL and testbench
================================

Name: count_arbiter

Overview:
- Race-free arbiter and sequencer for a shared WIDTH-bit event counter incremented by NUM_REQ independent requesters.
- Serialises increments through a round-robin grant, so counter updates never depend on process scheduling order.
- Keeps a per-requester tally and stops after NUM_TESTS total grants.
- Sits between stimulus processes and the shared counter in race-study testbenches.

Parameters:
- NUM_REQ, 2, number of requesters (>=2)
- WIDTH, 8, shared counter and tally width
- NUM_TESTS, 100, total grants per run; TW = $clog2(NUM_TESTS+1)

Ports:
- clk  in  1  sole clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- start  in  1  level-sampled run request
- req  in  NUM_REQ  increment request, one bit per requester, held until granted
- gnt  out  NUM_REQ  registered one-hot grant, one-cycle pulse per accepted increment
- count  out  WIDTH  shared counter
- tally  out  NUM_REQ*WIDTH  packed per-requester grant counts; requester i at [i*WIDTH +: WIDTH]
- total  out  TW  grants in the current run
- busy  out  1  high in RUN
- done  out  1  high in DONE

Behaviour:
- Reset (async, immediate):
  - state=IDLE, ptr=0.
  - gnt, count, tally, total, busy and done all go to 0.
- FSM IDLE:
  - gnt=0.
  - start=1 at an edge: go to RUN; clear count, tally, total and ptr at that same edge.
- FSM RUN:
  - Eligible set: elig = req & ~gnt. A requester granted in this cycle is masked for one cycle, so a held req is never double-counted.
  - If elig is nonzero, the winner w is the first set bit searching from ptr upward, wrapping modulo NUM_REQ.
  - At the edge: gnt<=onehot(w), count<=count+1, tally[w]<=tally[w]+1, total<=total+1, ptr<=(w+1) mod NUM_REQ.
  - If elig is zero: gnt<=0 and everything else holds.
  - Latency: req sampled at edge N, gnt high cycle N..N+1, count updated at the same edge.
  - At the edge where total becomes NUM_TESTS: go to DONE. That grant still issues; no further grants follow.
  - start is ignored while in RUN.
- FSM DONE:
  - gnt=0, busy=0, done=1.
  - count, tally and total hold.
  - start=1: go back to RUN with the same clearing as in IDLE.
- Arithmetic:
  - count and tally wrap modulo 2^WIDTH with no saturation.
  - total never exceeds NUM_TESTS.
- Invariants, checked by concurrent assertions in the bench:
  - $onehot0(gnt).
  - count == (sum of tallies) mod 2^WIDTH.
  - Sum of un-wrapped tallies == total.
  - gnt nonzero only in the cycle after a RUN edge.
- Simultaneous start and rst: rst wins.
- req changing while gnt is high: no effect on the current grant.

Decomposition:
- Package count_arbiter_pkg:
  - state_e enum {IDLE, RUN, DONE}
  - parameterised helper function onehot_idx
- Sub-module rr_pick (combinational): inputs elig[NUM_REQ] and ptr; outputs valid and winner index. Rotate, priority-encode, unrotate.
- All state and arithmetic stay in count_arbiter.

Test Plan (defaults unless stated):
- Both req held high after start → gnt 01,10,01,… every cycle; after 100 grants done=1, count=100, tally0=50, tally1=50, total=100, no further gnt.
- Only req[1] held → gnt[1] every other cycle; done after 199 cycles with tally1=100, tally0=0, count=100.
- WIDTH=4, NUM_TESTS=20, both held → count=4 (wrapped), tally0=tally1=10, total=20.
- Both req rise together in the first RUN cycle with ptr=0 → gnt[0] first, then gnt[1], ptr returns to 0.
- rst pulsed after 10 grants → outputs zero immediately without a clock edge; state IDLE; count stays 0 until start.
- start pulsed mid-RUN → ignored, counts continue; start in DONE → count/tally/total cleared, new 100-grant run completes.

Source files
------------

// File: rtl/count_arbiter_pkg.sv
// Shared types and helpers for the round-robin event-counter arbiter.
package count_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    localparam int IDX_MAXW = 32;

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int onehot_idx(input logic [IDX_MAXW-1:0] v);
        int idx;
        idx = 0;
        for (int i = IDX_MAXW - 1; i >= 0; i--) begin
            if (v[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/count_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate by ptr, priority-encode, unrotate.
module rr_pick
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_elig,
    input  logic [PW-1:0]      i_ptr,
    output logic               o_valid,
    output logic [PW-1:0]      o_winner
);

    logic [IDX_MAXW-1:0] w_rot;
    int                  w_idx;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_rot[k] = i_elig[(k + int'(i_ptr)) % NUM_REQ];
        end
        w_idx = onehot_idx(w_rot) + int'(i_ptr);
        if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
        o_valid  = |i_elig;
        o_winner = PW'(w_idx);
    end

endmodule

// File: rtl/count_arbiter.sv
// Serialises increments of a shared counter from NUM_REQ requesters
// through a round-robin grant and stops after NUM_TESTS grants.
module count_arbiter
    import count_arbiter_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int WIDTH     = 8,
    parameter int NUM_TESTS = 100
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [NUM_REQ-1:0]               req,
    output logic [NUM_REQ-1:0]               gnt,
    output logic [WIDTH-1:0]                 count,
    output logic [NUM_REQ*WIDTH-1:0]         tally,
    output logic [$clog2(NUM_TESTS+1)-1:0]   total,
    output logic                             busy,
    output logic                             done
);

    localparam int TW = $clog2(NUM_TESTS + 1);
    localparam int PW = $clog2(NUM_REQ);

    state_e                     r_state;
    state_e                     w_state_nxt;
    logic [NUM_REQ-1:0]         r_gnt;
    logic [WIDTH-1:0]           r_count;
    logic [NUM_REQ*WIDTH-1:0]   r_tally;
    logic [TW-1:0]              r_total;
    logic [PW-1:0]              r_ptr;

    logic [NUM_REQ-1:0]         w_elig;
    logic                       w_valid;
    logic [PW-1:0]              w_win;
    logic                       w_take;
    logic                       w_last;
    logic                       w_clr;

    // Last cycle's winner is masked so a still-held req is not counted twice.
    assign w_elig = req & ~r_gnt;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_pick (
        .i_elig   (w_elig),
        .i_ptr    (r_ptr),
        .o_valid  (w_valid),
        .o_winner (w_win)
    );

    assign w_take = (r_state == RUN) && w_valid;
    assign w_last = w_take && (r_total == TW'(NUM_TESTS - 1));
    assign w_clr  = start && (r_state != RUN);

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (start)  w_state_nxt = RUN;
            RUN:     if (w_last) w_state_nxt = DONE;
            DONE:    if (start)  w_state_nxt = RUN;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gnt   <= '0;
            r_count <= '0;
            r_tally <= '0;
            r_total <= '0;
            r_ptr   <= '0;
        end else begin
            r_gnt <= '0;
            if (w_clr) begin
                r_count <= '0;
                r_tally <= '0;
                r_total <= '0;
                r_ptr   <= '0;
            end else if (w_take) begin
                r_gnt   <= NUM_REQ'(1) << w_win;
                r_count <= r_count + WIDTH'(1);
                r_tally[int'(w_win)*WIDTH +: WIDTH] <=
                    r_tally[int'(w_win)*WIDTH +: WIDTH] + WIDTH'(1);
                r_total <= r_total + TW'(1);
                r_ptr   <= (int'(w_win) == NUM_REQ - 1) ? '0 : w_win + PW'(1);
            end
        end
    end

    assign gnt   = r_gnt;
    assign count = r_count;
    assign tally = r_tally;
    assign total = r_total;
    assign busy  = (r_state == RUN);
    assign done  = (r_state == DONE);

endmodule

// File: tb/tb_count_arbiter.sv
// Randomised and directed bench for count_arbiter with a behavioural model.
module tb_count_arbiter;

    localparam int NUM_REQ   = 2;
    localparam int WIDTH     = 8;
    localparam int NUM_TESTS = 100;
    localparam int TW        = $clog2(NUM_TESTS + 1);
    localparam int M_IDLE    = 0;
    localparam int M_RUN     = 1;
    localparam int M_DONE    = 2;

    logic                       clk = 1'b0;
    logic                       rst = 1'b1;
    logic                       start = 1'b0;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ-1:0]         gnt;
    logic [WIDTH-1:0]           count;
    logic [NUM_REQ*WIDTH-1:0]   tally;
    logic [TW-1:0]              total;
    logic                       busy;
    logic                       done;

    logic                       rst4 = 1'b1;
    logic                       start4 = 1'b0;
    logic [1:0]                 req4 = '0;
    logic [1:0]                 gnt4;
    logic [3:0]                 count4;
    logic [7:0]                 tally4;
    logic [4:0]                 total4;
    logic                       busy4;
    logic                       done4;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    count_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .WIDTH     (WIDTH),
        .NUM_TESTS (NUM_TESTS)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .req   (req),
        .gnt   (gnt),
        .count (count),
        .tally (tally),
        .total (total),
        .busy  (busy),
        .done  (done)
    );

    count_arbiter #(
        .NUM_REQ   (2),
        .WIDTH     (4),
        .NUM_TESTS (20)
    ) u_dut4 (
        .clk   (clk),
        .rst   (rst4),
        .start (start4),
        .req   (req4),
        .gnt   (gnt4),
        .count (count4),
        .tally (tally4),
        .total (total4),
        .busy  (busy4),
        .done  (done4)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
                     $time);
        end
    endtask

    // Behavioural model: integer tallies, a search loop for the winner.
    int m_mode = M_IDLE;
    int m_ptr = 0;
    int m_gnt = -1;
    int m_total = 0;
    int m_tally[NUM_REQ] = '{default: 0};
    int m_w;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_mode  = M_IDLE;
            m_ptr   = 0;
            m_gnt   = -1;
            m_total = 0;
            foreach (m_tally[i]) m_tally[i] = 0;
        end else if (m_mode == M_RUN) begin
            m_w = -1;
            for (int k = 0; k < NUM_REQ; k++) begin
                if (m_w < 0 && req[(m_ptr + k) % NUM_REQ] &&
                    ((m_ptr + k) % NUM_REQ) != m_gnt)
                    m_w = (m_ptr + k) % NUM_REQ;
            end
            m_gnt = m_w;
            if (m_w >= 0) begin
                m_tally[m_w]++;
                m_total++;
                m_ptr = (m_w + 1) % NUM_REQ;
                if (m_total == NUM_TESTS) m_mode = M_DONE;
            end
        end else begin
            m_gnt = -1;
            if (start) begin
                m_mode  = M_RUN;
                m_ptr   = 0;
                m_total = 0;
                foreach (m_tally[i]) m_tally[i] = 0;
            end
        end
    end

    initial forever begin
        logic [NUM_REQ-1:0]       e_gnt;
        logic [NUM_REQ*WIDTH-1:0] e_tally;
        int                       e_sum;
        @(negedge clk);
        e_gnt = '0;
        if (m_gnt >= 0) e_gnt[m_gnt] = 1'b1;
        e_tally = '0;
        e_sum   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            e_tally[i*WIDTH +: WIDTH] = WIDTH'(m_tally[i] % (1 << WIDTH));
            e_sum += m_tally[i];
        end
        chk("gnt", 64'(gnt), 64'(e_gnt));
        chk("count", 64'(count), 64'(e_sum % (1 << WIDTH)));
        chk("tally", 64'(tally), 64'(e_tally));
        chk("total", 64'(total), 64'(m_total));
        chk("busy", 64'(busy), 64'(m_mode == M_RUN));
        chk("done", 64'(done), 64'(m_mode == M_DONE));
    end

    logic [WIDTH-1:0] t_sum_w;
    logic [15:0]      t_sum_u;
    always_comb begin
        t_sum_w = '0;
        t_sum_u = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            t_sum_w = t_sum_w + tally[i*WIDTH +: WIDTH];
            t_sum_u = t_sum_u + 16'(tally[i*WIDTH +: WIDTH]);
        end
    end

    a_onehot: assert property (@(posedge clk) disable iff (rst)
        $onehot0(gnt)) else $error("gnt not onehot0");
    a_sum: assert property (@(posedge clk) disable iff (rst)
        count == t_sum_w) else $error("count != tally sum");
    a_total: assert property (@(posedge clk) disable iff (rst)
        t_sum_u == 16'(total)) else $error("tally sum != total");
    a_gnt_run: assert property (@(posedge clk) disable iff (rst)
        (|gnt) |-> $past(busy)) else $error("gnt outside RUN");

    int cyc;

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 0);
        chk("rst_count", 64'(count), 0);
        chk("rst_busy", 64'(busy), 0);
        rst = 1'b0;
        rst4 = 1'b0;
        repeat (2) @(negedge clk);

        // Both held: alternating grants, 100 grants total.
        start = 1'b1;
        req   = 2'b11;
        @(negedge clk);
        start = 1'b0;
        chk("t1_first_gnt0", 64'(gnt), 0);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) chk("t1_gnt_c1", 64'(gnt), 64'h1);
            if (cyc == 2) chk("t1_gnt_c2", 64'(gnt), 64'h2);
            if (cyc == 3) chk("t1_gnt_c3", 64'(gnt), 64'h1);
        end
        chk("t1_cycles", 64'(cyc), 100);
        chk("t1_count", 64'(count), 100);
        chk("t1_tally0", 64'(tally[7:0]), 50);
        chk("t1_tally1", 64'(tally[15:8]), 50);
        chk("t1_total", 64'(total), 100);
        repeat (3) @(negedge clk);
        chk("t1_no_more_gnt", 64'(gnt), 0);
        chk("t1_count_hold", 64'(count), 100);

        // Restart from DONE with only req[1]; a mid-run start is ignored.
        req   = 2'b10;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t2_clr_count", 64'(count), 0);
        chk("t2_clr_total", 64'(total), 0);
        cyc = 0;
        while (!done && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            start = (cyc == 20);
        end
        start = 1'b0;
        chk("t2_cycles", 64'(cyc), 199);
        chk("t2_tally0", 64'(tally[7:0]), 0);
        chk("t2_tally1", 64'(tally[15:8]), 100);
        chk("t2_count", 64'(count), 100);

        // Async reset after 10 grants.
        req   = 2'b11;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (m_total < 10 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t3_pre_total", 64'(total), 10);
        #2 rst = 1'b1;
        #1;
        chk("t3_async_gnt", 64'(gnt), 0);
        chk("t3_async_count", 64'(count), 0);
        chk("t3_async_tally", 64'(tally), 0);
        chk("t3_async_total", 64'(total), 0);
        chk("t3_async_busy", 64'(busy), 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("t3_idle_count", 64'(count), 0);
        chk("t3_idle_busy", 64'(busy), 0);

        // Random requests and occasional start pulses.
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            req   = NUM_REQ'($urandom);
            start = ($urandom_range(0, 39) == 0);
        end
        start = 1'b0;
        req   = '0;

        // Narrow instance: count wraps modulo 16.
        @(negedge clk);
        start4 = 1'b1;
        req4   = 2'b11;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0;
        while (!done4 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("t4_cycles", 64'(cyc), 20);
        chk("t4_count", 64'(count4), 4);
        chk("t4_tally0", 64'(tally4[3:0]), 10);
        chk("t4_tally1", 64'(tally4[7:4]), 10);
        chk("t4_total", 64'(total4), 20);
        @(negedge clk);
        chk("t4_gnt_idle", 64'(gnt4), 0);
        chk("t4_busy", 64'(busy4), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
